// File: rtl/decompressor.sv
// Run-length decompressor: fetches compressed words, expands (run, value) pairs
// into a dense byte stream and emits fixed-size packets.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | fetching words and expanding pairs into packets
// DRAIN | last packet transferred, waiting for in-flight words to return
// DONE  | one-cycle decompressor_ack, then back to IDLE
module decompressor #(
   parameter int MEM_BW_BYTES   = 8,
   parameter int PKT_BYTES      = 8,
   parameter int WORD_BUF_DEPTH = 4,
   parameter int L1_BYTES       = 512,
   parameter int L2_BYTES       = 1024,
   parameter int L3_BYTES       = 2048
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [1:0]                   layer_type_in,
   input  logic                         mem_ack,
   output logic                         mem_req,
   input  logic [MEM_BW_BYTES*8-1:0]    mem_data,
   input  logic                         mem_data_valid,
   input  logic                         ifmap_buffer_req,
   output logic                         decompressor_ack,
   output logic [2+PKT_BYTES*8-1:0]     decompress_fifo_packet
);
   localparam int MEM_W     = MEM_BW_BYTES * 8;
   localparam int PAIRS     = MEM_BW_BYTES / 2;
   localparam int PIDX_W    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
   localparam int MAX_BYTES = (L3_BYTES > L2_BYTES) ? ((L3_BYTES > L1_BYTES) ? L3_BYTES : L1_BYTES)
                                                    : ((L2_BYTES > L1_BYTES) ? L2_BYTES : L1_BYTES);
   localparam int CNT_W     = $clog2(MAX_BYTES + 1);
   localparam int FILL_W    = $clog2(PKT_BYTES + 1);
   localparam int BSEL_W    = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
   localparam int OCC_W     = $clog2(WORD_BUF_DEPTH + 1);
   localparam int PTR_W     = (WORD_BUF_DEPTH > 1) ? $clog2(WORD_BUF_DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                 state, state_nx;
   logic [CNT_W-1:0]       target, byte_cnt;
   logic [MEM_W-1:0]       word_buf [WORD_BUF_DEPTH];
   logic [PTR_W-1:0]       rd_ptr, wr_ptr;
   logic [OCC_W-1:0]       buf_cnt, outst, stale;
   logic [PIDX_W-1:0]      pair_idx;
   logic [7:0]             rem;
   logic                   rem_loaded;
   logic [PKT_BYTES*8-1:0] pkt_data, data_nx;
   logic [FILL_W-1:0]      fill, base, fill_nx;
   logic                   pkt_valid, pkt_last;

   logic [MEM_W-1:0]       head;
   logic [15:0]            cur_pair;
   logic [7:0]             eff_rem;
   logic [CNT_W-1:0]       slots, left, n_zero, wr_n, byte_nx;
   logic                   xfer, live, can_step, do_zero, do_val, pop, push, pkt_done;
   logic                   ret_stale, ret_live;
   logic [OCC_W+1:0]       occ;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(WORD_BUF_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      xfer     = pkt_valid && ifmap_buffer_req;
      live     = (state == RUN) && !start && (byte_cnt < target);
      head     = word_buf[rd_ptr];
      cur_pair = head[{pair_idx, 4'b0000} +: 16];
      eff_rem  = rem_loaded ? rem : cur_pair[15:8];
      // a transferring packet frees the whole register in the same cycle
      base     = xfer ? '0 : fill;
      slots    = CNT_W'(PKT_BYTES) - CNT_W'(base);
      left     = target - byte_cnt;
      n_zero   = CNT_W'(eff_rem);
      if (slots < n_zero) n_zero = slots;
      if (left < n_zero)  n_zero = left;
      can_step = live && (buf_cnt != '0) && (base != FILL_W'(PKT_BYTES));
      do_zero  = can_step && (eff_rem != 8'd0);
      do_val   = can_step && (eff_rem == 8'd0);
      wr_n     = do_zero ? n_zero : (do_val ? CNT_W'(1) : '0);
      byte_nx  = byte_cnt + wr_n;
      fill_nx  = base + FILL_W'(wr_n);
      pkt_done = (wr_n != '0) && (fill_nx == FILL_W'(PKT_BYTES));
      pop      = do_val && (pair_idx == PIDX_W'(PAIRS - 1));
      data_nx  = xfer ? '0 : pkt_data;
      if (do_val) data_nx[{base[BSEL_W-1:0], 3'b000} +: 8] = cur_pair[7:0];

      ret_stale = mem_data_valid && (stale != '0);
      ret_live  = mem_data_valid && (stale == '0) && (outst != '0);
      push      = ret_live && live;
      // words from an abandoned layer still hold credit until they return
      occ       = (OCC_W+2)'(outst) + (OCC_W+2)'(stale) + (OCC_W+2)'(buf_cnt);
      mem_req   = live && mem_ack && (occ < (OCC_W+2)'(WORD_BUF_DEPTH));
   end

   always_comb begin
      state_nx = state;
      if (start) begin
         state_nx = RUN;
      end else begin
         case (state)
            IDLE:    state_nx = IDLE;
            RUN:     if (xfer && pkt_last) state_nx = DRAIN;
            DRAIN:   if ((outst == '0) && (stale == '0)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) word_buf[wr_ptr] <= mem_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         target     <= '0;
         byte_cnt   <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         buf_cnt    <= '0;
         outst      <= '0;
         stale      <= '0;
         pair_idx   <= '0;
         rem        <= '0;
         rem_loaded <= 1'b0;
         pkt_data   <= '0;
         fill       <= '0;
         pkt_valid  <= 1'b0;
         pkt_last   <= 1'b0;
      end else begin
         state <= state_nx;
         if (start) begin
            case (layer_type_in)
               2'd0:    target <= CNT_W'(L1_BYTES);
               2'd1:    target <= CNT_W'(L2_BYTES);
               default: target <= CNT_W'(L3_BYTES);
            endcase
            byte_cnt   <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            buf_cnt    <= '0;
            outst      <= '0;
            stale      <= stale + outst - OCC_W'(mem_data_valid && ((stale != '0) || (outst != '0)));
            pair_idx   <= '0;
            rem        <= '0;
            rem_loaded <= 1'b0;
            pkt_data   <= '0;
            fill       <= '0;
            pkt_valid  <= 1'b0;
            pkt_last   <= 1'b0;
         end else begin
            outst <= outst + OCC_W'(mem_req) - OCC_W'(ret_live);
            if (ret_stale) stale <= stale - 1'b1;
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            buf_cnt <= buf_cnt + OCC_W'(push) - OCC_W'(pop);
            if (do_zero) begin
               rem        <= eff_rem - 8'(n_zero);
               rem_loaded <= 1'b1;
            end
            if (do_val) begin
               rem_loaded <= 1'b0;
               pair_idx   <= pop ? '0 : pair_idx + 1'b1;
            end
            byte_cnt <= byte_nx;
            fill     <= fill_nx;
            pkt_data <= data_nx;
            if (pkt_done) begin
               pkt_valid <= 1'b1;
               pkt_last  <= (byte_nx == target);
            end else if (xfer) begin
               pkt_valid <= 1'b0;
               pkt_last  <= 1'b0;
            end
         end
      end
   end

   assign decompressor_ack       = (state == DONE);
   assign decompress_fifo_packet = {pkt_valid, pkt_last, pkt_data};

endmodule

// File: tb/tb_decompressor.sv
// Self-checking bench for decompressor: table-driven layers, hand sequences for
// long runs, back-pressure and restart, plus randomized throttling vs a byte model.
module tb_decompressor;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst, start, mem_ack, mem_req, mem_data_valid, ifmap_buffer_req, decompressor_ack;
   logic [1:0]  layer_type_in;
   logic [63:0] mem_data;
   logic [65:0] dfp;

   always #5 clk = ~clk;

   decompressor dut (
      .clk(clk), .rst(rst), .start(start), .layer_type_in(layer_type_in),
      .mem_ack(mem_ack), .mem_req(mem_req), .mem_data(mem_data),
      .mem_data_valid(mem_data_valid), .ifmap_buffer_req(ifmap_buffer_req),
      .decompressor_ack(decompressor_ack), .decompress_fifo_packet(dfp)
   );

   typedef struct { int due; logic [63:0] data; } resp_t;
   typedef struct { logic [1:0] layer; logic [63:0] word; int exp_pkts; logic [63:0] exp_first; } vec_t;

   int n_cmp = 0, n_fail = 0;
   int cyc = 0, last_due = 0;
   int ack_pct = 100, rdy_pct = 100, lat_min = 1, lat_max = 4;
   resp_t pend[$];
   logic [63:0] cur_words[$], next_words[$];
   logic [7:0]  gold[$];
   int widx = 0, npkts = 0, rx_cnt = 0, ack_cnt = 0, req_total = 0, mem_out = 0;
   logic [63:0] rx_data [256];
   vec_t vecs[4];

   task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int tgt_of(input int layer);
      return (layer == 0) ? 512 : (layer == 1) ? 1024 : 2048;
   endfunction

   // reference model: expand every pair of the stream into a flat byte list
   task automatic build_gold(input int tgt);
      logic [63:0] wd;
      int pr, w;
      gold.delete();
      w = 0;
      while (gold.size() < tgt) begin
         wd = (w < cur_words.size()) ? cur_words[w] : 64'd0;
         for (int p = 0; p < 4; p++) begin
            pr = int'((wd >> (16 * p)) & 64'hFFFF);
            repeat (pr / 256) gold.push_back(8'h00);
            gold.push_back(8'(pr % 256));
         end
         w++;
      end
      while (gold.size() > tgt) void'(gold.pop_back());
      npkts = tgt / 8;
   endtask

   task automatic gen_random(input int tgt);
      int bytes, run;
      logic [63:0] w;
      next_words.delete();
      bytes = 0;
      while (bytes < tgt + 64) begin
         w = 64'd0;
         for (int p = 0; p < 4; p++) begin
            run = ($urandom_range(7) == 0) ? int'($urandom_range(255)) : int'($urandom_range(2));
            w = w | (64'(run * 256 + int'($urandom_range(255))) << (16 * p));
            bytes += run + 1;
         end
         next_words.push_back(w);
      end
   endtask

   task automatic fill_pattern(input logic [63:0] w, input int n);
      next_words.delete();
      for (int i = 0; i < n; i++) next_words.push_back(w);
   endtask

   task automatic check_packet();
      logic [63:0] exp;
      int idx;
      idx = rx_cnt;
      if (idx < npkts) begin
         exp = 64'd0;
         for (int k = 0; k < 8; k++) exp[8*k +: 8] = gold[idx*8 + k];
         check("pkt_data", {2'b00, dfp[63:0]}, {2'b00, exp});
         check("pkt_last", {65'd0, dfp[64]}, {65'd0, (idx == npkts - 1)});
         if (idx < 256) rx_data[idx] = dfp[63:0];
      end else begin
         check("extra_pkt", 66'(idx), 66'(npkts));
      end
      rx_cnt++;
   endtask

   // memory + downstream model: sample at negedge, drive just after posedge
   initial begin
      resp_t r;
      mem_ack = 1'b0; mem_data_valid = 1'b0; mem_data = '0; ifmap_buffer_req = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (dfp[65] && ifmap_buffer_req) check_packet();
            if (decompressor_ack) ack_cnt++;
            if (mem_req) begin
               check("mem_req_needs_ack", {65'd0, mem_ack}, 66'd1);
               r.due = cyc + int'($urandom_range(lat_max, lat_min));
               if (r.due <= last_due) r.due = last_due + 1;
               last_due = r.due;
               r.data = (widx < cur_words.size()) ? cur_words[widx] : 64'd0;
               widx++;
               pend.push_back(r);
               mem_out++;
               req_total++;
               check("outstanding_le_depth", {65'd0, mem_out <= DEPTH}, 66'd1);
            end
         end
         @(posedge clk);
         cyc++;
         #1;
         mem_ack          = ($urandom_range(99) < ack_pct);
         ifmap_buffer_req = ($urandom_range(99) < rdy_pct);
         if (pend.size() > 0 && pend[0].due <= cyc) begin
            mem_data_valid = 1'b1;
            mem_data       = pend[0].data;
            void'(pend.pop_front());
            mem_out--;
         end else begin
            mem_data_valid = 1'b0;
         end
      end
   end

   // downstream is held off during the start cycle so no packet straddles a restart
   task automatic do_start(input int layer);
      int saved;
      saved = rdy_pct;
      @(posedge clk); #2 rdy_pct = 0;
      @(posedge clk); #2;
      cur_words     = next_words;
      widx          = 0;
      build_gold(tgt_of(layer));
      rx_cnt        = 0;
      ack_cnt       = 0;
      layer_type_in = 2'(layer);
      start         = 1'b1;
      @(posedge clk); #2;
      start   = 1'b0;
      rdy_pct = saved;
   endtask

   task automatic wait_ack(input int limit);
      int i;
      i = 0;
      while (ack_cnt == 0 && i < limit) begin
         @(negedge clk);
         i++;
      end
      if (ack_cnt == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL ack_timeout: got no ack after %0d cycles, required one", limit);
      end
      repeat (6) @(negedge clk);
   endtask

   initial begin
      logic [65:0] cap;
      int r20, i;
      vecs[0] = '{2'd0, 64'h0044_0033_0022_0011, 64,  64'h4433_2211_4433_2211};
      vecs[1] = '{2'd1, 64'h0344_0033_0122_0011, 128, 64'h4400_0000_3322_0011};
      vecs[2] = '{2'd2, 64'h0000_0000_0000_0700, 256, 64'h0000_0000_0000_0000};
      vecs[3] = '{2'd3, 64'h02AA_01BB_00CC_03DD, 256, 64'h00BB_00CC_DD00_0000};

      rst = 1'b1; start = 1'b0; layer_type_in = 2'd0;
      ack_pct = 100;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_mem_req", {65'd0, mem_req}, 66'd0);
      check("reset_ack", {65'd0, decompressor_ack}, 66'd0);
      check("reset_packet", dfp, 66'd0);
      @(posedge clk); #2 rst = 1'b0;

      for (int v = 0; v < 4; v++) begin
         ack_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 4;
         fill_pattern(vecs[v].word, 600);
         do_start(int'(vecs[v].layer));
         wait_ack(20000);
         check("vec_pkt_count", 66'(rx_cnt), 66'(vecs[v].exp_pkts));
         check("vec_first_pkt", {2'b00, rx_data[0]}, {2'b00, vecs[v].exp_first});
         check("vec_ack_once", 66'(ack_cnt), 66'd1);
      end

      // longest run: 255 zeros then 0xAB lands at dense byte 255
      next_words.delete();
      next_words.push_back(64'h0000_0000_0000_FFAB);
      for (int k = 0; k < 600; k++) next_words.push_back(64'd0);
      do_start(2);
      wait_ack(20000);
      check("longrun_pkt30", {2'b00, rx_data[30]}, 66'd0);
      check("longrun_pkt31", {2'b00, rx_data[31]}, {2'b00, 64'hAB00_0000_0000_0000});
      check("longrun_pkt32", {2'b00, rx_data[32]}, 66'd0);
      check("longrun_pkt_count", 66'(rx_cnt), 66'd256);
      check("longrun_ack_once", 66'(ack_cnt), 66'd1);

      // random throttle on all three handshakes
      ack_pct = 60; rdy_pct = 60; lat_min = 1; lat_max = 12;
      gen_random(2048);
      do_start(2);
      wait_ack(40000);
      check("random_pkt_count", 66'(rx_cnt), 66'd256);
      check("random_ack_once", 66'(ack_cnt), 66'd1);

      // back-pressure: packet must hold and requests must run out of credit
      ack_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 4;
      gen_random(512);
      do_start(0);
      i = 0;
      while (rx_cnt < 10 && i < 3000) begin @(negedge clk); i++; end
      rdy_pct = 0;
      repeat (12) @(negedge clk);
      cap = dfp;
      check("bp_valid_held", {65'd0, cap[65]}, 66'd1);
      r20 = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         check("bp_pkt_stable", dfp, cap);
         if (c == 20) r20 = req_total;
      end
      check("bp_req_stopped", 66'(req_total), 66'(r20));
      rdy_pct = 100;
      wait_ack(20000);
      check("bp_pkt_count", 66'(rx_cnt), 66'd64);
      check("bp_ack_once", 66'(ack_cnt), 66'd1);

      // restart mid-layer with words still in flight
      ack_pct = 100; rdy_pct = 100; lat_min = 15; lat_max = 25;
      gen_random(2048);
      do_start(2);
      i = 0;
      while (!(rx_cnt >= 3 && mem_out >= 2) && i < 3000) begin @(negedge clk); i++; end
      check("restart_in_flight", {65'd0, mem_out >= 2}, 66'd1);
      gen_random(1024);
      lat_min = 1; lat_max = 6;
      do_start(1);
      wait_ack(20000);
      check("restart_pkt_count", 66'(rx_cnt), 66'd128);
      check("restart_ack_once", 66'(ack_cnt), 66'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
